and_unit_arbiter: RTL
=====================

Name: and_unit_arbiter

Overview:
- Sequencing and sharing controller for the 16-bit bitwise AND unit.
- Two independent requesters submit operand pairs over valid/ready handshakes; a round-robin arbiter grants one at a time.
- The granted pair is captured, ANDed, and returned as a 32-bit zero-extended result with a requester ID over a valid/ready response channel.
- Sits between the instruction-decode/requester logic and the shared logic datapath.

Parameters:
- DATA_W, 16, operand width in bits.
- RES_W, 32, result width in bits; result is zero-extended from DATA_W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req0Valid  input  1  requester 0 has an operand pair.
- req0Ready  output  1  requester 0 pair accepted this cycle.
- req0A  input  DATA_W  requester 0 operand A.
- req0B  input  DATA_W  requester 0 operand B.
- req1Valid, req1Ready, req1A, req1B: same as requester 0, for requester 1.
- rspValid  output  1  result available.
- rspReady  input  1  consumer accepts result.
- rspData  output  RES_W  result: zero-extended (A & B).
- rspId  output  1  requester that owns rspData (0 or 1).

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; priority pointer selects requester 0.
  - rspValid=0, rspData=0, rspId=0; captured operands cleared.
  - req0Ready=req1Ready=0 while in reset.
  - Reset mid-operation (CALC or HOLD) discards the in-flight operation; no response is produced for it.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - reqNReady is combinational: high only for the granted requester, and only when in IDLE with that reqNValid high.
  - Grant rule: if only one valid is high, grant it. If both are high, grant the requester selected by the priority pointer.
  - On the accepting edge (valid && ready): capture A, B and ID; set the priority pointer to the other requester; go to CALC.
  - No valid: stay in IDLE.
- CALC, one cycle:
  - rspData <= {(RES_W-DATA_W){0}, capA & capB}; rspId <= captured ID; rspValid <= 1.
  - Go to HOLD.
- HOLD:
  - rspValid, rspData and rspId stay stable until rspValid && rspReady at a rising edge.
  - On that edge: rspValid <= 0 and go to IDLE.
  - Both reqNReady stay 0 throughout CALC and HOLD.
- Latency and throughput:
  - Accept at edge N gives rspValid high after edge N+1 (visible in the cycle after CALC).
  - Minimum spacing between accepts is 3 cycles (IDLE, CALC, HOLD with rspReady already high).
- Requester rule: once reqNValid is high, it must stay high with A/B stable until reqNReady. The block does not check this.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- A requester whose valid is low is never granted; the pointer is unchanged when no grant occurs.
- rspData bits [RES_W-1:DATA_W] are always 0.

Optional Feature:
- Macro: AND_ARB_STATS_EN.
- Defined:
  - Adds output ports grantCount0 and grantCount1, each 16 bits.
  - Each counter increments on every accept of its requester and wraps 0xFFFF to 0x0000.
  - Both counters reset to 0 on rst_n.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: req0A=0xF0F0, req0B=0xFF00, rspReady=1 -> req0Ready for 1 cycle; rspValid one cycle after CALC with rspData=0x0000F000, rspId=0.
- Simultaneous request after reset: both valid; req0 A/B=0xFFFF/0x1234, req1 A/B=0x0F0F/0xFFFF -> req0 served first (rspData=0x00001234, rspId=0), then req1 (rspData=0x00000F0F, rspId=1).
- Continuous contention: both valid for 8 ops -> rspId sequence 0,1,0,1,0,1,0,1.
- Backpressure: rspReady=0 for 5 cycles in HOLD -> rspValid/rspData/rspId stable and both reqNReady=0; rspReady=1 -> return to IDLE next edge.
- Mid-operation reset: rst_n=0 during CALC with req1 0xAAAA/0x5555 -> rspValid=0, rspData=0 next edge; after release, a req0-only request is served with rspId=0 and no stale response.
- Stats (AND_ARB_STATS_EN defined): 65537 req0 accepts -> grantCount0=0x0001, grantCount1=0x0000.

Source files
------------

// File: rtl/and_unit_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit AND unit.
// Optional grant counters are enabled with the AND_ARB_STATS_EN macro.
module and_unit_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0Valid,
  output logic              req0Ready,
  input  logic [DATA_W-1:0] req0A,
  input  logic [DATA_W-1:0] req0B,
  input  logic              req1Valid,
  output logic              req1Ready,
  input  logic [DATA_W-1:0] req1A,
  input  logic [DATA_W-1:0] req1B,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [RES_W-1:0]  rspData,
`ifdef AND_ARB_STATS_EN
  output logic [15:0]       grantCount0,
  output logic [15:0]       grantCount1,
`endif
  output logic              rspId
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;
  logic [DATA_W-1:0]   r_cap_a;
  logic [DATA_W-1:0]   r_cap_b;
  logic                r_cap_id;
  logic                r_rsp_valid;
  logic [RES_W-1:0]    r_rsp_data;
  logic                r_rsp_id;
  logic                w_gnt_id;
  logic                w_accept;
  logic                w_req0_ready;
  logic                w_req1_ready;
  logic                w_rsp_done;

  // Grant: a lone valid wins; on contention the priority pointer decides.
  assign w_gnt_id = (req0Valid && req1Valid) ? r_ptr : req1Valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req0_ready = rst_n && req0Valid && !w_gnt_id;
        w_req1_ready = rst_n && req1Valid &&  w_gnt_id;
        if (w_req0_ready || w_req1_ready) w_state_nxt = ST_CALC;
      end
      ST_CALC: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        w_rsp_done = r_rsp_valid && rspReady;
        if (w_rsp_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = w_req0_ready || w_req1_ready;

  // Operand capture, pointer update and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_cap_a     <= '0;
      r_cap_b     <= '0;
      r_cap_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cap_a  <= w_gnt_id ? req1A : req0A;
        r_cap_b  <= w_gnt_id ? req1B : req0B;
        r_cap_id <= w_gnt_id;
        r_ptr    <= !w_gnt_id;
      end
      if (r_state == ST_CALC) begin
        r_rsp_data  <= RES_W'(r_cap_a & r_cap_b);
        r_rsp_id    <= r_cap_id;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef AND_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  // Per-requester accept counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_req0_ready) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_req1_ready) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign grantCount0 = r_cnt0;
  assign grantCount1 = r_cnt1;
`endif

  assign req0Ready = w_req0_ready;
  assign req1Ready = w_req1_ready;
  assign rspValid  = r_rsp_valid;
  assign rspData   = r_rsp_data;
  assign rspId     = r_rsp_id;

endmodule
